bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using the double-dabble algorithm: one bit per clock, with a per-digit add-3 correction.
- Sits between the Basys 3 switch/binary datapath and the BCD-consuming display logic.
- Accepts one binary word per start request and returns packed BCD digits with a one-cycle done pulse.
- Converts one input at a time; the core is not pipelined.

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin2bcd_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W      : bits per BCD digit
//   ADJ_THRESH   : digit value at or above which the add-3 correction applies
//   ADJ_ADD      : correction added before each shift
//   conv_state_t : controller state encoding
//   pow10()      : 10^n, a constant helper for expected-result arithmetic
package bcd_pkg;
  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_ADD    = 4'd3;

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} conv_state_t;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit.
//   i_d : scratch digit before the shift
//   o_d : i_d + 3 when i_d >= 5, else i_d (4-bit wrap)
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_d,
  output logic [DIGIT_W-1:0] o_d
);
  assign o_d = (i_d >= ADJ_THRESH) ? i_d + ADJ_ADD : i_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : conversion request, sampled only while idle
//   bin_in    : binary operand, captured when start is accepted
//   busy      : conversion in progress
//   done      : one-cycle pulse; bcd_out/overflow valid from this cycle
//   bcd_out   : packed BCD, units digit in [3:0]; value is input mod 10^DIGITS
//   overflow  : input was >= 10^DIGITS; held alongside bcd_out
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BIN_W-1:0]           bin_in,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*DIGITS-1:0]  bcd_out,
  output logic                       overflow
);
  localparam int SW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  conv_state_t       r_state, w_state_nxt;
  logic [BIN_W-1:0]  r_bin;
  logic [SW-1:0]     r_scr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic [SW-1:0]     r_bcd;
  logic              r_ovf_out;
  logic              r_done;

  logic [SW-1:0]     w_adj;
  logic [SW-1:0]     w_scr_nxt;
  logic              w_ovf_nxt;
  logic              w_last;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_d (r_scr[g*DIGIT_W +: DIGIT_W]),
        .o_d (w_adj[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Adjust then shift; the bit leaving the top digit means the value no longer
  // fits in DIGITS digits, so it is latched into the sticky overflow.
  assign w_scr_nxt = {w_adj[SW-2:0], r_bin[BIN_W-1]};
  assign w_ovf_nxt = r_ovf | w_adj[SW-1];
  assign w_last    = (r_cnt == CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = CONVERT;
      CONVERT: if (w_last) w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin     <= '0;
      r_scr     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_bin <= bin_in;
          r_scr <= '0;
          r_ovf <= 1'b0;
          r_cnt <= CW'(BIN_W);
        end
        CONVERT: begin
          r_bin <= r_bin << 1;
          r_scr <= w_scr_nxt;
          r_ovf <= w_ovf_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_bcd     <= w_scr_nxt;
            r_ovf_out <= w_ovf_nxt;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == CONVERT);
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf_out;
endmodule
